pc_fetch_sequencer: RTL and testbench

Multi-cycle instruction-fetch sequencer for the processor datapath. It owns the program counter register and drives the instruction-memory request/acknowledge handshake. It issues one fetched instruction at a time to the execute stage and selects the next PC: sequential PC+4, branch target or jump target. It sits between the instruction memory and the decode/execute logic and is the only writer of the PC.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/program_counter_adder.sv | 12 +
 rtl/pc_fetch_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM states,
// instruction width and the sequential PC increment.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    localparam int unsigned         INSTR_W = 32;
    localparam logic [INSTR_W-1:0] PC_INC  = 32'd4;

    // Word-align an address by clearing its two low bits.
    function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
        return addr & ~INSTR_W'(3);
    endfunction

endpackage

// File: rtl/program_counter_adder.sv
// Sequential-PC adder: 32-bit modulo sum of the current PC and the increment.
module program_counter_adder
    import pc_seq_pkg::*;
(
    input  logic [INSTR_W-1:0] pc,
    input  logic [INSTR_W-1:0] inc,
    output logic [INSTR_W-1:0] sum
);

    assign sum = pc + inc;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Multi-cycle fetch sequencer: owns the PC, runs the imem handshake and selects the next PC.
// Optional fetch-wait timeout enabled by defining PC_SEQ_TIMEOUT_EN.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned        TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [INSTR_W-1:0] branch_target,
    input  logic               jump,
    input  logic [INSTR_W-1:0] jump_target,
    input  logic               halt,
    output logic [INSTR_W-1:0] pc,
    output logic               halted,
    output logic               fetch_error
);

    seq_state_t         state, state_nx;
    logic [INSTR_W-1:0] pc_q, pc_nx, pc_plus4, instr_q;
    logic               req_q, req_nx, halted_q, halted_nx;
    logic               instr_load, ack_ok, timeout_hit;

    program_counter_adder u_pc_adder (
        .pc  (pc_q),
        .inc (PC_INC),
        .sum (pc_plus4)
    );

    // imem_req is registered so it is low during reset and rises on the first edge after release;
    // an ack is only accepted once the request is actually visible.
    assign ack_ok = (state == FETCH) && req_q && imem_ack;

`ifdef PC_SEQ_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout_hit = (state == FETCH) && req_q && !imem_ack
                         && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != FETCH)
                wait_cnt <= '0;
            else if (req_q && !imem_ack && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign fetch_error = err_q;
`else
    // Without the timeout the limit has no effect; the parameter stays for interface compatibility.
    assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
    assign fetch_error = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        pc_nx      = pc_q;
        halted_nx  = halted_q;
        instr_load = 1'b0;
        case (state)
            FETCH: begin
                if (ack_ok) begin
                    instr_load = 1'b1;
                    state_nx   = ISSUE;
                end else if (timeout_hit) begin
                    state_nx  = HALT;
                    halted_nx = 1'b1;
                end
            end
            ISSUE: state_nx = EXEC;
            EXEC: begin
                if (exec_done) begin
                    if (halt) begin
                        state_nx  = HALT;
                        halted_nx = 1'b1;
                    end else begin
                        state_nx = FETCH;
                        if (jump)
                            pc_nx = align_word(jump_target);
                        else if (branch_taken)
                            pc_nx = align_word(branch_target);
                        else
                            pc_nx = pc_plus4;
                    end
                end
            end
            default: state_nx = HALT;
        endcase
        req_nx = (state_nx == FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            pc_q     <= align_word(RESET_VECTOR);
            instr_q  <= '0;
            req_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_q     <= pc_nx;
            req_q    <= req_nx;
            halted_q <= halted_nx;
            if (instr_load)
                instr_q <= imem_rdata;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state == ISSUE);
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized self-checking bench for pc_fetch_sequencer against a transaction-level PC model.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, instr_valid, halted, fetch_error;
    logic [31:0] imem_addr, instr, pc;
    logic        imem_ack = 1'b0, exec_done = 1'b0, branch_taken = 1'b0, jump = 1'b0, halt = 1'b0;
    logic [31:0] imem_rdata = '0, branch_target = '0, jump_target = '0;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [31:0] m_pc;

    pc_fetch_sequencer #(
        .RESET_VECTOR   (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt          (halt),
        .pc            (pc),
        .halted        (halted),
        .fetch_error   (fetch_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: wait ack_dly FETCH cycles, fetch word, wait done_dly EXEC cycles, then retire.
    task automatic run_instr(input int unsigned ack_dly, input logic [31:0] word,
                             input int unsigned done_dly, input logic h,
                             input logic j, input logic [31:0] jt,
                             input logic b, input logic [31:0] bt);
        for (int i = 0; i < int'(ack_dly); i++) begin
            chk("req_wait", imem_req, 1);
            chk("addr_stable", imem_addr, m_pc);
            chk("valid_wait", instr_valid, 0);
            imem_rdata = $urandom;
            tick();
        end
        chk("req_fetch", imem_req, 1);
        chk("addr_fetch", imem_addr, m_pc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("req_drop", imem_req, 0);
        chk("valid", instr_valid, 1);
        chk("instr", instr, word);
        // exec_done (even with halt) must be ignored while issuing
        exec_done = 1'b1;
        halt      = 1'($urandom_range(0, 1));
        tick();
        exec_done = 1'b0;
        halt      = 1'b0;
        chk("valid_pulse", instr_valid, 0);
        chk("req_exec", imem_req, 0);
        chk("halted_exec", halted, 0);
        for (int i = 0; i < int'(done_dly); i++) begin
            imem_ack      = 1'($urandom_range(0, 1));
            jump          = 1'($urandom_range(0, 1));
            branch_taken  = 1'($urandom_range(0, 1));
            jump_target   = $urandom;
            branch_target = $urandom;
            tick();
            chk("req_wait_exec", imem_req, 0);
            chk("valid_wait_exec", instr_valid, 0);
            chk("pc_wait_exec", pc, m_pc);
        end
        imem_ack      = 1'b0;
        exec_done     = 1'b1;
        halt          = h;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        tick();
        exec_done = 1'b0; halt = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        if (h) begin
            chk("halted", halted, 1);
            chk("req_halt", imem_req, 0);
            chk("pc_halt", pc, m_pc);
            for (int i = 0; i < 8; i++) begin
                imem_ack  = 1'($urandom_range(0, 1));
                exec_done = 1'($urandom_range(0, 1));
                jump      = 1'b1;
                jump_target = $urandom;
                tick();
                chk("req_halt_hold", imem_req, 0);
                chk("valid_halt_hold", instr_valid, 0);
                chk("pc_halt_hold", pc, m_pc);
                chk("halted_hold", halted, 1);
            end
            imem_ack = 1'b0; exec_done = 1'b0; jump = 1'b0;
        end else begin
            if (j)      m_pc = jt & 32'hFFFF_FFFC;
            else if (b) m_pc = bt & 32'hFFFF_FFFC;
            else        m_pc = m_pc + 32'd4;
            chk("pc_next", pc, m_pc);
            chk("addr_next", imem_addr, m_pc);
            chk("req_next", imem_req, 1);
            chk("halted_run", halted, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_ferr", fetch_error, 0);
        @(negedge clk);
        reset = 1'b0;
        m_pc  = 32'h0;
        tick();
        chk("req_after_rst", imem_req, 1);
        chk("addr_after_rst", imem_addr, 32'h0);
    endtask

    initial begin
        m_pc = 32'h0;
        do_reset();

        run_instr(0, 32'h2001_0005, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("seq_addr", imem_addr, 32'h0000_0004);
        run_instr(1, $urandom, 0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0043);
        chk("branch_addr", imem_addr, 32'h0000_0040);
        run_instr(0, $urandom, 2, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0040);
        chk("prio_pc", pc, 32'h0000_0100);
        run_instr(0, $urandom, 0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        chk("top_pc", pc, 32'hFFFF_FFFC);
        run_instr(0, $urandom, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0000);
        run_instr(5, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

        // asynchronous reset in the middle of a fetch wait
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_valid", instr_valid, 0);
        chk("async_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_pc  = 32'h0;
        tick();
        chk("req_after_async", imem_req, 1);

        for (int n = 0; n < 30; n++) begin
            run_instr($urandom_range(0, 4), $urandom, $urandom_range(0, 3), 1'b0,
                      ($urandom_range(0, 3) == 0), $urandom,
                      ($urandom_range(0, 2) == 0), $urandom);
        end

        run_instr(1, $urandom, 1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("ferr_after_halt", fetch_error, 0);

`ifdef PC_SEQ_TIMEOUT_EN
        do_reset();
        for (int i = 0; i < 20; i++) tick();
        chk("timeout_err", fetch_error, 1);
        chk("timeout_halted", halted, 1);
        chk("timeout_req", imem_req, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
